// File: rtl/led_tat_dan_tsp_pst_if.sv
// Control and LED bus of the progressive turn-off chaser.
//   SS    run (1) / pause (0)
//   MODE  1 = drain from LSB end, 0 = drain from MSB end
//   LED   N-bit LED pattern
//   BUSY  FSM is not idle
//   DONE  one-cycle pulse when the pattern drains to all-zero
// master: drives SS/MODE and observes the LED bank (board / bench side).
// slave : the chaser itself.
interface led_tat_dan_tsp_pst_if #(
  parameter int N = 8
);
  logic         SS;
  logic         MODE;
  logic [N-1:0] LED;
  logic         BUSY;
  logic         DONE;

  modport master (output SS, output MODE, input LED, input BUSY, input DONE);
  modport slave  (input SS, input MODE, output LED, output BUSY, output DONE);
endinterface

// File: rtl/led_tat_dan_tsp_pst.sv
// Progressive turn-off LED chaser. On start it lights all N LEDs, then
// turns them off one per step from the LSB or MSB end (MODE). Once dark,
// the all-zero pattern is held for HOLD steps, then all-ones reloads and
// the drain repeats. A step is DIV SS-high clock edges; SS=0 freezes all.
// Ports:
//   Clk    system clock, rising edge
//   RST_n  asynchronous active-low reset
//   bus    slave modport: SS, MODE in; LED[N-1:0], BUSY, DONE out
module led_tat_dan_tsp_pst #(
  parameter int N    = 8,
  parameter int DIV  = 1,
  parameter int HOLD = 2
) (
  input  logic                  Clk,
  input  logic                  RST_n,
  led_tat_dan_tsp_pst_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD_ST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  led_q, led_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          done_q, done_d;
  logic          tick;
  logic          busy;
  logic [N-1:0]  shifted;

  assign tick = bus.SS & (pcnt_q == PMAX);

  // State register: FSM state plus the datapath it owns.
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      led_q   <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Without a tick nothing but the prescaler moves, so
  // SS=0 freezes everything and forces DONE low.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    pcnt_d  = pcnt_q;
    shifted = '0;

    if (bus.SS) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          led_d   = '1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          // MODE applies to the current pattern as is; a mid-run flip
          // simply changes shift direction without re-normalising.
          shifted = bus.MODE ? (led_q << 1) : (led_q >> 1);
          led_d   = shifted;
          if (shifted == '0) begin
            done_d  = 1'b1;
            hcnt_d  = '0;
            state_d = HOLD_ST;
          end
        end
      end
      HOLD_ST: begin
        if (tick) begin
          if (hcnt_q == HMAX) begin
            led_d   = '1;
            state_d = RUN;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      default: begin
        // Unused encoding: return to a clean idle on the next edge.
        state_d = IDLE;
        led_d   = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q != IDLE);
  end

  assign bus.LED  = led_q;
  assign bus.BUSY = busy;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_led_tat_dan_tsp_pst.sv
// Directed bench for the turn-off chaser: one instance with DIV=1 and one
// with DIV=4, N=8, HOLD=2, sharing clock and reset.
module tb_led_tat_dan_tsp_pst;

  logic Clk;
  logic RST_n;
  int   n_checks;
  int   n_fail;

  led_tat_dan_tsp_pst_if #(.N(8)) if1 ();
  led_tat_dan_tsp_pst_if #(.N(8)) if4 ();

  led_tat_dan_tsp_pst #(.N(8), .DIV(1), .HOLD(2)) dut1 (
    .Clk   (Clk),
    .RST_n (RST_n),
    .bus   (if1)
  );

  led_tat_dan_tsp_pst #(.N(8), .DIV(4), .HOLD(2)) dut4 (
    .Clk   (Clk),
    .RST_n (RST_n),
    .bus   (if4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] seq_lsb [11] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0,
                               8'h80, 8'h00, 8'h00, 8'hFF, 8'hFE};
  logic [7:0] seq_msb [11] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07,
                               8'h03, 8'h01, 8'h00, 8'h00, 8'hFF};

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Hold reset for a few edges, release away from the clock edge.
  task automatic do_reset();
    RST_n = 1'b0;
    step();
    step();
    RST_n = 1'b1;
  endtask

  task automatic test_reset();
    if1.SS = 1'b1; if1.MODE = 1'b1;
    if4.SS = 1'b0; if4.MODE = 1'b1;
    RST_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (if1.LED !== 8'h00 || if1.BUSY !== 1'b0 || if1.DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: LED=%h BUSY=%b DONE=%b, required LED=00 BUSY=0 DONE=0",
                 i, if1.LED, if1.BUSY, if1.DONE);
      end
    end
    RST_n = 1'b1;
    step();
    n_checks++;
    if (if1.LED !== 8'hFF || if1.BUSY !== 1'b1 || if1.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: LED=%h BUSY=%b DONE=%b, required LED=FF BUSY=1 DONE=0",
               if1.LED, if1.BUSY, if1.DONE);
    end
  endtask

  // Continues from the FF left by test_reset.
  task automatic test_drain_lsb();
    for (int i = 0; i < 11; i++) begin
      step();
      n_checks++;
      if (if1.LED !== seq_lsb[i] || if1.DONE !== (i == 7) || if1.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_lsb step%0d: LED=%h DONE=%b BUSY=%b, required LED=%h DONE=%b BUSY=1",
                 i, if1.LED, if1.DONE, if1.BUSY, seq_lsb[i], (i == 7));
      end
    end
  endtask

  task automatic test_drain_msb();
    if1.MODE = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step();
      n_checks++;
      if (if1.LED !== seq_msb[i] || if1.DONE !== (i == 8) || if1.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_msb step%0d: LED=%h DONE=%b BUSY=%b, required LED=%h DONE=%b BUSY=1",
                 i, if1.LED, if1.DONE, if1.BUSY, seq_msb[i], (i == 8));
      end
    end
  endtask

  task automatic test_pause();
    if1.MODE = 1'b1;
    do_reset();
    step(); step(); step();
    n_checks++;
    if (if1.LED !== 8'hFC) begin
      n_fail++;
      $display("FAIL pause_setup: LED=%h, required FC", if1.LED);
    end
    if1.SS = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (if1.LED !== 8'hFC || if1.DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold cyc%0d: LED=%h DONE=%b, required LED=FC DONE=0",
                 i, if1.LED, if1.DONE);
      end
    end
    if1.SS = 1'b1;
    step();
    n_checks++;
    if (if1.LED !== 8'hF8) begin
      n_fail++;
      $display("FAIL pause_resume: LED=%h, required F8", if1.LED);
    end
  endtask

  task automatic test_prescaler();
    logic [7:0] expv;
    if1.SS = 1'b0;
    if4.MODE = 1'b1;
    if4.SS = 1'b0;
    do_reset();
    if4.SS = 1'b1;
    // Edges 1..8: FF on the 4th SS-high edge, FE on the 8th.
    for (int e = 1; e <= 8; e++) begin
      step();
      expv = (e < 4) ? 8'h00 : ((e < 8) ? 8'hFF : 8'hFE);
      n_checks++;
      if (if4.LED !== expv) begin
        n_fail++;
        $display("FAIL prescale edge%0d: LED=%h, required %h", e, if4.LED, expv);
      end
    end
    // Two SS-high edges, two paused, then two more: FC lands 2 cycles late.
    step(); step();
    if4.SS = 1'b0;
    step(); step();
    if4.SS = 1'b1;
    step();
    n_checks++;
    if (if4.LED !== 8'hFE) begin
      n_fail++;
      $display("FAIL prescale_stretch_early: LED=%h, required FE", if4.LED);
    end
    step();
    n_checks++;
    if (if4.LED !== 8'hFC) begin
      n_fail++;
      $display("FAIL prescale_stretch: LED=%h, required FC", if4.LED);
    end
    if4.SS = 1'b0;
  endtask

  task automatic test_async_reset();
    if1.SS = 1'b1;
    if1.MODE = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (if1.LED !== 8'hF0) begin
      n_fail++;
      $display("FAIL async_setup: LED=%h, required F0", if1.LED);
    end
    #2;
    RST_n = 1'b0;
    #1;
    n_checks++;
    if (if1.LED !== 8'h00 || if1.BUSY !== 1'b0 || if1.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: LED=%h BUSY=%b DONE=%b, required LED=00 BUSY=0 DONE=0",
               if1.LED, if1.BUSY, if1.DONE);
    end
    step();
    RST_n = 1'b1;
    step();
    n_checks++;
    if (if1.LED !== 8'hFF || if1.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL async_restart: LED=%h BUSY=%b, required LED=FF BUSY=1",
               if1.LED, if1.BUSY);
    end
    step();
    n_checks++;
    if (if1.LED !== 8'hFE) begin
      n_fail++;
      $display("FAIL async_restart_step: LED=%h, required FE", if1.LED);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_n    = 1'b0;
    if1.SS = 1'b0; if1.MODE = 1'b1;
    if4.SS = 1'b0; if4.MODE = 1'b1;
    #1;
    test_reset();
    test_drain_lsb();
    test_drain_msb();
    test_pause();
    test_prescaler();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
